// File: rtl/clock_hms_param_if.sv
// Bus for clock_hms_param: control/load inputs and time/pulse outputs.
// master : drives en, dec, mode12, load and load_h/m/s; observes the time and pulses.
// slave  : the clock core; consumes controls and drives hour/min/sec BCD, pm, pulses.
interface clock_hms_param_if;
  logic       en;
  logic       dec;
  logic       mode12;
  logic       load;
  logic [7:0] load_h;
  logic [7:0] load_m;
  logic [7:0] load_s;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       pm;
  logic       sec_tick;
  logic       min_carry;
  logic       hour_carry;
  logic       day_carry;
  logic       load_err;

  modport master (
    output en, dec, mode12, load, load_h, load_m, load_s,
    input  hour_bcd, min_bcd, sec_bcd, pm, sec_tick, min_carry, hour_carry, day_carry,
           load_err
  );

  modport slave (
    input  en, dec, mode12, load, load_h, load_m, load_s,
    output hour_bcd, min_bcd, sec_bcd, pm, sec_tick, min_carry, hour_carry, day_carry,
           load_err
  );
endinterface

// File: rtl/clock_hms_param.sv
// BCD HH:MM:SS time-of-day counter with built-in prescaler (one second = TICK_DIV
// enabled cycles), up/down counting, synchronous validated load and 12/24-hour display.
// Ports:
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   io_bus  : clock_hms_param_if.slave (controls, load values, time outputs, pulses)
module clock_hms_param #(
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned DIV_W    = 7
) (
  input logic              i_clk,
  input logic              i_rst_n,
  clock_hms_param_if.slave io_bus
);

  localparam logic [DIV_W-1:0] DivLast = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_s0, r_s1, r_m0, r_m1, r_h0, r_h1;
  logic             r_sec_tick, r_min_carry, r_hour_carry, r_day_carry, r_load_err;

  logic             w_tick;
  logic             w_load_ok;
  logic [3:0]       w_s0, w_s1, w_m0, w_m1, w_h0, w_h1;
  logic             w_sec_wrap, w_min_wrap, w_day_wrap;
  logic [4:0]       w_hour_bin;
  logic [4:0]       w_hour12;
  logic [7:0]       w_hour12_bcd;

  assign w_tick = io_bus.en && (r_div == DivLast);

  // Hours must be 00-23; minutes/seconds tens 0-5 and every units digit 0-9.
  assign w_load_ok =
      ((io_bus.load_h[7:4] < 4'd2 && io_bus.load_h[3:0] <= 4'd9) ||
       (io_bus.load_h[7:4] == 4'd2 && io_bus.load_h[3:0] <= 4'd3)) &&
      io_bus.load_m[7:4] <= 4'd5 && io_bus.load_m[3:0] <= 4'd9 &&
      io_bus.load_s[7:4] <= 4'd5 && io_bus.load_s[3:0] <= 4'd9;

  // Next time on a tick, with the wrap flags that become the carry pulses.
  always_comb begin
    w_s0       = r_s0;
    w_s1       = r_s1;
    w_m0       = r_m0;
    w_m1       = r_m1;
    w_h0       = r_h0;
    w_h1       = r_h1;
    w_sec_wrap = 1'b0;
    w_min_wrap = 1'b0;
    w_day_wrap = 1'b0;
    if (!io_bus.dec) begin
      if (r_s0 != 4'd9) begin
        w_s0 = r_s0 + 4'd1;
      end else begin
        w_s0 = 4'd0;
        if (r_s1 != 4'd5) begin
          w_s1 = r_s1 + 4'd1;
        end else begin
          w_s1       = 4'd0;
          w_sec_wrap = 1'b1;
        end
      end
      if (w_sec_wrap) begin
        if (r_m0 != 4'd9) begin
          w_m0 = r_m0 + 4'd1;
        end else begin
          w_m0 = 4'd0;
          if (r_m1 != 4'd5) begin
            w_m1 = r_m1 + 4'd1;
          end else begin
            w_m1       = 4'd0;
            w_min_wrap = 1'b1;
          end
        end
      end
      if (w_min_wrap) begin
        if (r_h1 == 4'd2 && r_h0 == 4'd3) begin
          w_h1       = 4'd0;
          w_h0       = 4'd0;
          w_day_wrap = 1'b1;
        end else if (r_h0 == 4'd9) begin
          w_h0 = 4'd0;
          w_h1 = r_h1 + 4'd1;
        end else begin
          w_h0 = r_h0 + 4'd1;
        end
      end
    end else begin
      if (r_s0 != 4'd0) begin
        w_s0 = r_s0 - 4'd1;
      end else begin
        w_s0 = 4'd9;
        if (r_s1 != 4'd0) begin
          w_s1 = r_s1 - 4'd1;
        end else begin
          w_s1       = 4'd5;
          w_sec_wrap = 1'b1;
        end
      end
      if (w_sec_wrap) begin
        if (r_m0 != 4'd0) begin
          w_m0 = r_m0 - 4'd1;
        end else begin
          w_m0 = 4'd9;
          if (r_m1 != 4'd0) begin
            w_m1 = r_m1 - 4'd1;
          end else begin
            w_m1       = 4'd5;
            w_min_wrap = 1'b1;
          end
        end
      end
      if (w_min_wrap) begin
        if (r_h1 == 4'd0 && r_h0 == 4'd0) begin
          w_h1       = 4'd2;
          w_h0       = 4'd3;
          w_day_wrap = 1'b1;
        end else if (r_h0 == 4'd0) begin
          w_h0 = 4'd9;
          w_h1 = r_h1 - 4'd1;
        end else begin
          w_h0 = r_h0 - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div        <= '0;
      r_s0         <= 4'd0;
      r_s1         <= 4'd0;
      r_m0         <= 4'd0;
      r_m1         <= 4'd0;
      r_h0         <= 4'd0;
      r_h1         <= 4'd0;
      r_sec_tick   <= 1'b0;
      r_min_carry  <= 1'b0;
      r_hour_carry <= 1'b0;
      r_day_carry  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_sec_tick   <= 1'b0;
      r_min_carry  <= 1'b0;
      r_hour_carry <= 1'b0;
      r_day_carry  <= 1'b0;
      r_load_err   <= 1'b0;
      if (io_bus.load) begin
        // Load overrides any coincident tick; a rejected load leaves everything held.
        if (w_load_ok) begin
          r_div <= '0;
          r_h1  <= io_bus.load_h[7:4];
          r_h0  <= io_bus.load_h[3:0];
          r_m1  <= io_bus.load_m[7:4];
          r_m0  <= io_bus.load_m[3:0];
          r_s1  <= io_bus.load_s[7:4];
          r_s0  <= io_bus.load_s[3:0];
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (io_bus.en) begin
        if (w_tick) begin
          r_div        <= '0;
          r_s0         <= w_s0;
          r_s1         <= w_s1;
          r_m0         <= w_m0;
          r_m1         <= w_m1;
          r_h0         <= w_h0;
          r_h1         <= w_h1;
          r_sec_tick   <= 1'b1;
          r_min_carry  <= w_sec_wrap;
          r_hour_carry <= w_min_wrap;
          r_day_carry  <= w_day_wrap;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  // 12-hour view: 0 -> 12, 13..23 -> minus 12, otherwise unchanged.
  always_comb begin
    w_hour_bin = 5'(r_h1) * 5'd10 + 5'(r_h0);
    if (w_hour_bin == 5'd0) begin
      w_hour12 = 5'd12;
    end else if (w_hour_bin > 5'd12) begin
      w_hour12 = w_hour_bin - 5'd12;
    end else begin
      w_hour12 = w_hour_bin;
    end
    if (w_hour12 >= 5'd10) begin
      w_hour12_bcd = {4'd1, 4'(w_hour12 - 5'd10)};
    end else begin
      w_hour12_bcd = {4'd0, w_hour12[3:0]};
    end
  end

  assign io_bus.hour_bcd   = io_bus.mode12 ? w_hour12_bcd : {r_h1, r_h0};
  assign io_bus.min_bcd    = {r_m1, r_m0};
  assign io_bus.sec_bcd    = {r_s1, r_s0};
  assign io_bus.pm         = (w_hour_bin >= 5'd12);
  assign io_bus.sec_tick   = r_sec_tick;
  assign io_bus.min_carry  = r_min_carry;
  assign io_bus.hour_carry = r_hour_carry;
  assign io_bus.day_carry  = r_day_carry;
  assign io_bus.load_err   = r_load_err;

endmodule

// File: tb/tb_clock_hms_param.sv
module tb_clock_hms_param;
  localparam int unsigned TickDiv = 4;
  localparam int unsigned DivW    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  clock_hms_param_if bus ();

  clock_hms_param #(
    .TICK_DIV(TickDiv),
    .DIV_W   (DivW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: time as seconds of the day, prescaler as a plain count.
  int   m_t;
  int   m_p;
  logic e_tick, e_minc, e_hc, e_dc, e_err;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [7:0] b, input int maxv);
    return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (bcd_val(b) <= maxv);
  endfunction

  function automatic logic [23:0] exp_time();
    int h;
    h = m_t / 3600;
    if (bus.mode12) h = (h % 12 == 0) ? 12 : h % 12;
    return {to_bcd(h), to_bcd((m_t / 60) % 60), to_bcd(m_t % 60)};
  endfunction

  function automatic logic [5:0] exp_flags();
    return {e_tick, e_minc, e_hc, e_dc, e_err, logic'(m_t / 3600 >= 12)};
  endfunction

  task automatic model_reset();
    m_t = 0; m_p = 0;
    {e_tick, e_minc, e_hc, e_dc, e_err} = '0;
  endtask

  // Advance model by one clock with the current inputs, then step the DUT.
  task automatic cycle();
    {e_tick, e_minc, e_hc, e_dc, e_err} = '0;
    if (bus.load) begin
      if (bcd_ok(bus.load_h, 23) && bcd_ok(bus.load_m, 59) && bcd_ok(bus.load_s, 59)) begin
        m_t = bcd_val(bus.load_h) * 3600 + bcd_val(bus.load_m) * 60 + bcd_val(bus.load_s);
        m_p = 0;
      end else begin
        e_err = 1'b1;
      end
    end else if (bus.en) begin
      if (m_p == int'(TickDiv) - 1) begin
        m_p    = 0;
        e_tick = 1'b1;
        if (!bus.dec) begin
          e_minc = (m_t % 60 == 59);
          e_hc   = (m_t % 3600 == 3599);
          e_dc   = (m_t == 86399);
          m_t    = (m_t + 1) % 86400;
        end else begin
          e_minc = (m_t % 60 == 0);
          e_hc   = (m_t % 3600 == 0);
          e_dc   = (m_t == 0);
          m_t    = (m_t + 86399) % 86400;
        end
      end else begin
        m_p++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.load   = 1'b1;
    bus.load_h = h;
    bus.load_m = m;
    bus.load_s = s;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.dec = 1'b0; bus.mode12 = 1'b0; bus.load = 1'b0;
    bus.load_h = 8'h00; bus.load_m = 8'h00; bus.load_s = 8'h00;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.hour_bcd, bus.min_bcd, bus.sec_bcd} !== 24'h000000) begin
      failures++;
      $display("FAIL reset_time got=%h want=000000", {bus.hour_bcd, bus.min_bcd, bus.sec_bcd});
    end
    checks++;
    if ({bus.sec_tick, bus.min_carry, bus.hour_carry, bus.day_carry, bus.load_err, bus.pm}
        !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000000",
               {bus.sec_tick, bus.min_carry, bus.hour_carry, bus.day_carry, bus.load_err, bus.pm});
    end
    bus.mode12 = 1'b1;
    #1;
    checks++;
    if (bus.hour_bcd !== 8'h12) begin
      failures++;
      $display("FAIL reset_hour12 got=%h want=12", bus.hour_bcd);
    end
    bus.mode12 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    int ticks = 0, minc = 0, cyc = 0, last = 0;
    bus.en = 1'b1; bus.dec = 1'b0;
    while (ticks < 60 && cyc < 400) begin
      cycle();
      cyc++;
      checks++;
      if ({bus.hour_bcd, bus.min_bcd, bus.sec_bcd} !== exp_time()) begin
        failures++;
        $display("FAIL up_time got=%h want=%h", {bus.hour_bcd, bus.min_bcd, bus.sec_bcd},
                 exp_time());
      end
      if (bus.sec_tick) begin
        ticks++;
        checks++;
        if (cyc - last != int'(TickDiv)) begin
          failures++;
          $display("FAIL up_tick_period got=%0d want=%0d", cyc - last, TickDiv);
        end
        last = cyc;
        if (ticks == 1 || ticks == 10) begin
          checks++;
          if (bus.sec_bcd !== ((ticks == 1) ? 8'h01 : 8'h10)) begin
            failures++;
            $display("FAIL up_sec_at_tick%0d got=%h", ticks, bus.sec_bcd);
          end
        end
      end
      if (bus.min_carry) minc++;
    end
    checks++;
    if (ticks != 60 || minc != 1 || bus.sec_bcd !== 8'h00 || bus.min_bcd !== 8'h01) begin
      failures++;
      $display("FAIL up_60_ticks got ticks=%0d minc=%0d sec=%h min=%h want 60 1 00 01",
               ticks, minc, bus.sec_bcd, bus.min_bcd);
    end
  endtask

  task automatic test_day_wrap_up();
    int ticks = 0;
    bus.en = 1'b1; bus.dec = 1'b0;
    set_load(8'h23, 8'h59, 8'h58);
    cycle();
    bus.load = 1'b0;
    for (int i = 0; i < 12 && ticks < 2; i++) begin
      cycle();
      if (bus.sec_tick) begin
        ticks++;
        checks++;
        if (ticks == 1 && ({bus.hour_bcd, bus.min_bcd, bus.sec_bcd, bus.min_carry, bus.pm}
                           !== {24'h235959, 1'b0, 1'b1})) begin
          failures++;
          $display("FAIL dayup_first got=%h minc=%b pm=%b want 235959 0 1",
                   {bus.hour_bcd, bus.min_bcd, bus.sec_bcd}, bus.min_carry, bus.pm);
        end
        if (ticks == 2 && ({bus.hour_bcd, bus.min_bcd, bus.sec_bcd, bus.min_carry,
                            bus.hour_carry, bus.day_carry, bus.pm} !== {24'h000000, 4'b1110})) begin
          failures++;
          $display("FAIL dayup_wrap got=%h carries=%b pm=%b want 000000 111 0",
                   {bus.hour_bcd, bus.min_bcd, bus.sec_bcd},
                   {bus.min_carry, bus.hour_carry, bus.day_carry}, bus.pm);
        end
      end
    end
    cycle();
    checks++;
    if (ticks != 2 || {bus.min_carry, bus.hour_carry, bus.day_carry} !== 3'b000) begin
      failures++;
      $display("FAIL dayup_pulse_len got ticks=%0d carries=%b want 2 000", ticks,
               {bus.min_carry, bus.hour_carry, bus.day_carry});
    end
  endtask

  task automatic test_down_wrap();
    bit seen = 0;
    apply_reset();
    bus.en = 1'b1; bus.dec = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = bus.sec_tick;
    end
    checks++;
    if (!seen || {bus.hour_bcd, bus.min_bcd, bus.sec_bcd, bus.min_carry, bus.hour_carry,
                  bus.day_carry, bus.pm} !== {24'h235959, 4'b1111}) begin
      failures++;
      $display("FAIL down_wrap got tick=%b time=%h flags=%b want 1 235959 1111", seen,
               {bus.hour_bcd, bus.min_bcd, bus.sec_bcd},
               {bus.min_carry, bus.hour_carry, bus.day_carry, bus.pm});
    end
    bus.mode12 = 1'b1;
    #1;
    checks++;
    if (bus.hour_bcd !== 8'h11) begin
      failures++;
      $display("FAIL down_hour12 got=%h want=11", bus.hour_bcd);
    end
    bus.mode12 = 1'b0;
    bus.dec = 1'b0;
  endtask

  task automatic test_invalid_load();
    logic [7:0] bad [3][3];
    int gap = 0;
    bit seen = 0;
    bad[0] = '{8'h24, 8'h00, 8'h00};
    bad[1] = '{8'h10, 8'h20, 8'h5A};
    bad[2] = '{8'h10, 8'h60, 8'h00};
    bus.en = 1'b0;
    set_load(8'h10, 8'h20, 8'h30);
    cycle();
    for (int k = 0; k < 3; k++) begin
      set_load(bad[k][0], bad[k][1], bad[k][2]);
      cycle();
      bus.load = 1'b0;
      checks++;
      if (bus.load_err !== 1'b1 || {bus.hour_bcd, bus.min_bcd, bus.sec_bcd} !== 24'h102030) begin
        failures++;
        $display("FAIL bad_load%0d got err=%b time=%h want 1 102030", k, bus.load_err,
                 {bus.hour_bcd, bus.min_bcd, bus.sec_bcd});
      end
      cycle();
      checks++;
      if (bus.load_err !== 1'b0 || {bus.hour_bcd, bus.min_bcd, bus.sec_bcd} !== 24'h102030) begin
        failures++;
        $display("FAIL bad_load%0d_after got err=%b time=%h want 0 102030", k, bus.load_err,
                 {bus.hour_bcd, bus.min_bcd, bus.sec_bcd});
      end
    end
    // Load on the cycle the prescaler would tick.
    bus.en = 1'b1; bus.dec = 1'b0;
    for (int i = 0; i < 8 && m_p != int'(TickDiv) - 1; i++) cycle();
    set_load(8'h12, 8'h00, 8'h00);
    cycle();
    bus.load = 1'b0;
    checks++;
    if (bus.sec_tick !== 1'b0 || {bus.hour_bcd, bus.min_bcd, bus.sec_bcd} !== 24'h120000) begin
      failures++;
      $display("FAIL load_vs_tick got tick=%b time=%h want 0 120000", bus.sec_tick,
               {bus.hour_bcd, bus.min_bcd, bus.sec_bcd});
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      gap++;
      seen = bus.sec_tick;
    end
    checks++;
    if (!seen || gap != int'(TickDiv)) begin
      failures++;
      $display("FAIL load_next_tick got gap=%0d seen=%b want %0d", gap, seen, TickDiv);
    end
  endtask

  task automatic test_mode12_sweep();
    int         hrs [6] = '{0, 1, 11, 12, 13, 23};
    logic [7:0] disp[6] = '{8'h12, 8'h01, 8'h11, 8'h12, 8'h01, 8'h11};
    logic       pms [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.en = 1'b0;
    bus.mode12 = 1'b1;
    foreach (hrs[k]) begin
      set_load(to_bcd(hrs[k]), 8'h30, 8'h15);
      cycle();
      bus.load = 1'b0;
      checks++;
      if (bus.hour_bcd !== disp[k] || bus.pm !== pms[k]) begin
        failures++;
        $display("FAIL mode12_h%0d got hr=%h pm=%b want %h %b", hrs[k], bus.hour_bcd, bus.pm,
                 disp[k], pms[k]);
      end
    end
    bus.mode12 = 1'b0;
    #1;
    checks++;
    if (bus.hour_bcd !== 8'h23) begin
      failures++;
      $display("FAIL mode24_back got=%h want=23", bus.hour_bcd);
    end
  endtask

  task automatic test_enable_hold();
    int gap = 0;
    bit seen = 0;
    bus.en = 1'b1; bus.dec = 1'b0;
    set_load(8'h01, 8'h02, 8'h03);
    cycle();
    bus.load = 1'b0;
    cycle();
    cycle();
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (bus.sec_tick !== 1'b0 || {bus.hour_bcd, bus.min_bcd, bus.sec_bcd} !== 24'h010203) begin
        failures++;
        $display("FAIL en_hold got tick=%b time=%h want 0 010203", bus.sec_tick,
                 {bus.hour_bcd, bus.min_bcd, bus.sec_bcd});
      end
    end
    bus.en = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      gap++;
      seen = bus.sec_tick;
    end
    checks++;
    if (!seen || gap != 2 || {bus.hour_bcd, bus.min_bcd, bus.sec_bcd} !== 24'h010204) begin
      failures++;
      $display("FAIL en_resume got gap=%0d time=%h want 2 010204", gap,
               {bus.hour_bcd, bus.min_bcd, bus.sec_bcd});
    end
  endtask

  task automatic test_random();
    int picks[5] = '{86398, 59, 3599, 0, 43199};
    int t;
    for (int i = 0; i < 3000; i++) begin
      bus.en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) bus.dec = ~bus.dec;
      if ($urandom_range(0, 31) == 0) bus.mode12 = ~bus.mode12;
      bus.load = ($urandom_range(0, 39) == 0);
      if (bus.load) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.en = 1'b0;
          case ($urandom_range(0, 2))
            0:       set_load(to_bcd(int'($urandom_range(24, 29))), 8'h00, 8'h00);
            1:       set_load(8'h05, 8'h05, {4'h5, 4'($urandom_range(10, 15))});
            default: set_load(8'h05, {4'($urandom_range(6, 9)), 4'h0}, 8'h05);
          endcase
        end else begin
          t = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 4)]
                                          : int'($urandom_range(0, 86399));
          set_load(to_bcd(t / 3600), to_bcd((t / 60) % 60), to_bcd(t % 60));
        end
      end
      cycle();
      bus.load = 1'b0;
      checks++;
      if ({bus.hour_bcd, bus.min_bcd, bus.sec_bcd} !== exp_time()) begin
        failures++;
        $display("FAIL rand_time cyc=%0d got=%h want=%h", i,
                 {bus.hour_bcd, bus.min_bcd, bus.sec_bcd}, exp_time());
      end
      checks++;
      if ({bus.sec_tick, bus.min_carry, bus.hour_carry, bus.day_carry, bus.load_err, bus.pm}
          !== exp_flags()) begin
        failures++;
        $display("FAIL rand_flags cyc=%0d got=%b want=%b", i,
                 {bus.sec_tick, bus.min_carry, bus.hour_carry, bus.day_carry, bus.load_err,
                  bus.pm}, exp_flags());
      end
    end
    bus.dec = 1'b0;
    bus.mode12 = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    bit seen = 0;
    int gap = 0;
    bus.en = 1'b1; bus.dec = 1'b0;
    set_load(8'h00, 8'h00, 8'h59);
    cycle();
    bus.load = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = bus.min_carry;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL rst_pulse_seen got=0 want=1");
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.min_carry !== 1'b0 || {bus.hour_bcd, bus.min_bcd, bus.sec_bcd} !== 24'h000000) begin
      failures++;
      $display("FAIL rst_async got minc=%b time=%h want 0 000000", bus.min_carry,
               {bus.hour_bcd, bus.min_bcd, bus.sec_bcd});
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      gap++;
      seen = bus.sec_tick;
    end
    checks++;
    if (!seen || gap != int'(TickDiv) || bus.sec_bcd !== 8'h01) begin
      failures++;
      $display("FAIL rst_first_tick got gap=%0d sec=%h want %0d 01", gap, bus.sec_bcd, TickDiv);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_day_wrap_up();
    test_down_wrap();
    test_invalid_load();
    test_mode12_sweep();
    test_enable_hold();
    test_random();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
